// File: rtl/bayer_quad_packer_if.sv
// Stream interface for bayer_quad_packer: raw pixel input side and quad output side.
// master = upstream/downstream environment, slave = the packer itself.
// Optional in_sof exists only when BAYER_SOF_RESYNC_EN is defined.
interface bayer_quad_packer_if;
  logic [7:0]  in_pixel;
  logic        in_valid;
  logic        in_ready;
`ifdef BAYER_SOF_RESYNC_EN
  logic        in_sof;
`endif
  logic [31:0] out_quad;
  logic        out_valid;
  logic        out_ready;
  logic        frame_done;

`ifdef BAYER_SOF_RESYNC_EN
  modport master (output in_pixel, in_valid, in_sof, out_ready,
                  input  in_ready, out_quad, out_valid, frame_done);
  modport slave  (input  in_pixel, in_valid, in_sof, out_ready,
                  output in_ready, out_quad, out_valid, frame_done);
`else
  modport master (output in_pixel, in_valid, out_ready,
                  input  in_ready, out_quad, out_valid, frame_done);
  modport slave  (input  in_pixel, in_valid, out_ready,
                  output in_ready, out_quad, out_valid, frame_done);
`endif
endinterface

// File: rtl/bayer_quad_packer.sv
// Packs an RGGB raster pixel stream into one {R,Gr,Gb,B} word per 2x2 cell.
// Latency: quad registered one cycle after the B pixel transfer.
// Backpressure: in_ready = !out_valid || out_ready. Macro BAYER_SOF_RESYNC_EN adds in_sof realignment.
module bayer_quad_packer #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input logic                clk,
  input logic                n_rst,
  bayer_quad_packer_if.slave bus
);

  localparam int CW    = $clog2(WIDTH);
  localparam int RW    = $clog2(HEIGHT);
  localparam int DEPTH = WIDTH / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic {ROW_EVEN = 1'b0, ROW_ODD = 1'b1} state_t;

  state_t        state, state_nxt, cur_state;
  logic [CW-1:0] col, col_nxt, cur_col;
  logic [RW-1:0] row, row_nxt, cur_row;
  logic [7:0]    hold;
  logic [15:0]   line_buf [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0]   out_quad_q;
  logic          out_valid_q, frame_done_q;
  logic          in_ready, in_xfer, hold_ld, buf_wr, quad_ld, last_quad;

  assign in_ready       = !out_valid_q || bus.out_ready;
  assign in_xfer        = bus.in_valid && in_ready;
  assign bus.in_ready   = in_ready;
  assign bus.out_quad   = out_quad_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;

  // Position the current pixel occupies; a start-of-frame marker forces it to the frame origin.
  always_comb begin
    cur_col   = col;
    cur_row   = row;
    cur_state = state;
`ifdef BAYER_SOF_RESYNC_EN
    if (bus.in_sof) begin
      cur_col   = '0;
      cur_row   = '0;
      cur_state = ROW_EVEN;
    end
`endif
  end

  assign idx = AW'(cur_col >> 1);

  // Next position/state and the per-pixel action (hold, buffer write, quad load).
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    hold_ld   = 1'b0;
    buf_wr    = 1'b0;
    quad_ld   = 1'b0;
    last_quad = 1'b0;
    if (in_xfer) begin
      state_nxt = cur_state;
      col_nxt   = cur_col + CW'(1);
      row_nxt   = cur_row;
      if (cur_col == COL_LAST) begin
        col_nxt   = '0;
        row_nxt   = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        state_nxt = (cur_state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
      end
      if (!cur_col[0]) begin
        hold_ld = 1'b1;
      end else if (cur_state == ROW_EVEN) begin
        buf_wr = 1'b1;
      end else begin
        quad_ld   = 1'b1;
        last_quad = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      end
    end
  end

  // Row-parity FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ROW_EVEN;
    else        state <= state_nxt;
  end

  // Raster position counters and the first-pixel-of-pair hold register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col  <= '0;
      row  <= '0;
      hold <= '0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
      if (hold_ld) hold <= bus.in_pixel;
    end
  end

  // Even-row line buffer holding {R, Gr} per cell; contents need no reset.
  always_ff @(posedge clk) begin
    if (buf_wr) line_buf[idx] <= {hold, bus.in_pixel};
  end

  // Output register: a new quad load wins over a drain so back-to-back quads never bubble.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_quad_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= last_quad;
      if (quad_ld) begin
        out_quad_q  <= {line_buf[idx], hold, bus.in_pixel};
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bayer_quad_packer.sv
// Bench for bayer_quad_packer: directed tests on a 4x2 instance, randomized frames on an 8x4 instance.
// Expected quads come from the 2x2-cell definition applied to the pixel arrays the bench generates.
// Exercises in_sof realignment when BAYER_SOF_RESYNC_EN is defined.
module tb_bayer_quad_packer;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  bayer_quad_packer_if if_a ();
  bayer_quad_packer_if if_b ();

  bayer_quad_packer #(.WIDTH(4), .HEIGHT(2)) dut_a (.clk(clk), .n_rst(n_rst), .bus(if_a.slave));
  bayer_quad_packer #(.WIDTH(8), .HEIGHT(4)) dut_b (.clk(clk), .n_rst(n_rst), .bus(if_b.slave));

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  stream [8];
  localparam logic [31:0] Q1 = 32'h10203040;
  localparam logic [31:0] Q2 = 32'h11213141;

  task automatic idle_all();
    if_a.in_valid = 1'b0; if_a.in_pixel = 8'h00; if_a.out_ready = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_pixel = 8'h00; if_b.out_ready = 1'b0;
`ifdef BAYER_SOF_RESYNC_EN
    if_a.in_sof = 1'b0; if_b.in_sof = 1'b0;
`endif
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    idle_all();
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_all();
    n_rst = 1'b0;
    #1;
    vectors++;
    if ({if_a.out_valid, if_a.frame_done, if_a.out_quad} !== 34'h0) begin
      miscompares++;
      $display("FAIL reset_a: got valid=%b done=%b quad=%h, need 0/0/0", if_a.out_valid, if_a.frame_done, if_a.out_quad);
    end
    vectors++;
    if ({if_b.out_valid, if_b.frame_done, if_b.out_quad} !== 34'h0) begin
      miscompares++;
      $display("FAIL reset_b: got valid=%b done=%b quad=%h, need 0/0/0", if_b.out_valid, if_b.frame_done, if_b.out_quad);
    end
    vectors++;
    if (if_a.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b, need 1", if_a.in_ready);
    end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_basic();
    bit early_done = 1'b0;
    bit stalled    = 1'b0;
    reset_pulse();
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if_a.out_ready = 1'b1;
      if_a.in_valid  = (cyc < 8);
      if (cyc < 8) if_a.in_pixel = stream[cyc];
      #1;
      if (if_a.in_ready !== 1'b1) stalled = 1'b1;
      if (cyc < 8 && if_a.frame_done !== 1'b0) early_done = 1'b1;
      if (cyc == 6) begin
        vectors++;
        if (if_a.out_valid !== 1'b1 || if_a.out_quad !== Q1) begin
          miscompares++;
          $display("FAIL basic_q1: got valid=%b quad=%h, need 1 %h", if_a.out_valid, if_a.out_quad, Q1);
        end
      end
      if (cyc == 7) begin
        vectors++;
        if (if_a.out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_drain: got valid=%b, need 0", if_a.out_valid);
        end
      end
      if (cyc == 8) begin
        vectors++;
        if (if_a.out_valid !== 1'b1 || if_a.out_quad !== Q2 || if_a.frame_done !== 1'b1) begin
          miscompares++;
          $display("FAIL basic_q2: got valid=%b quad=%h done=%b, need 1 %h 1",
                   if_a.out_valid, if_a.out_quad, if_a.frame_done, Q2);
        end
      end
      if (cyc == 9) begin
        vectors++;
        if (if_a.frame_done !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_done_pulse: got %b, need 0", if_a.frame_done);
        end
      end
    end
    vectors++;
    if (early_done || stalled) begin
      miscompares++;
      $display("FAIL basic_flags: got early_done=%b stalled=%b, need 0 0", early_done, stalled);
    end
  endtask

  task automatic test_stall();
    logic [31:0] got [$];
    int idx = 0;
    reset_pulse();
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if_a.out_ready = !(cyc >= 6 && cyc < 10);
      if_a.in_valid  = (idx < 8);
      if (idx < 8) if_a.in_pixel = stream[idx];
      #1;
      if (cyc >= 6 && cyc < 10) begin
        vectors++;
        if (if_a.in_ready !== 1'b0 || if_a.out_valid !== 1'b1 || if_a.out_quad !== Q1) begin
          miscompares++;
          $display("FAIL stall_hold c%0d: got rdy=%b valid=%b quad=%h, need 0 1 %h",
                   cyc, if_a.in_ready, if_a.out_valid, if_a.out_quad, Q1);
        end
      end
      if (if_a.out_valid && if_a.out_ready) got.push_back(if_a.out_quad);
      if (if_a.in_valid && if_a.in_ready) idx++;
    end
    vectors++;
    if (got.size() != 2) begin
      miscompares++;
      $display("FAIL stall_count: got %0d quads, need 2", got.size());
    end else begin
      vectors++;
      if (got[0] !== Q1 || got[1] !== Q2) begin
        miscompares++;
        $display("FAIL stall_data: got %h %h, need %h %h", got[0], got[1], Q1, Q2);
      end
    end
  endtask

  task automatic test_midframe_reset();
    logic [31:0] got [$];
    int idx = 0;
    reset_pulse();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if_a.out_ready = 1'b1;
      if_a.in_valid  = 1'b1;
      if_a.in_pixel  = 8'(8'hE0 + i);
    end
    @(negedge clk);
    if_a.in_valid = 1'b0;
    n_rst = 1'b0;
    #1;
    vectors++;
    if (if_a.out_valid !== 1'b0 || if_a.out_quad !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_out: got valid=%b quad=%h, need 0 0", if_a.out_valid, if_a.out_quad);
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if_a.out_ready = 1'b1;
      if_a.in_valid  = (idx < 8);
      if (idx < 8) if_a.in_pixel = stream[idx];
      #1;
      if (if_a.out_valid && if_a.out_ready) got.push_back(if_a.out_quad);
      if (if_a.in_valid && if_a.in_ready) idx++;
    end
    vectors++;
    if (got.size() != 2 || got[0] !== Q1 || got[1] !== Q2) begin
      miscompares++;
      $display("FAIL midreset_quads: got n=%0d first=%h, need 2 quads starting %h",
               got.size(), (got.size() > 0) ? got[0] : 32'hx, Q1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] px [16];
    bit stalled = 1'b0;
    for (int i = 0; i < 16; i++) px[i] = 8'($urandom);
    reset_pulse();
    for (int cyc = 0; cyc < 18; cyc++) begin
      int p;
      logic        exp_v;
      logic [31:0] exp_q;
      @(negedge clk);
      if_a.out_ready = 1'b1;
      if_a.in_valid  = (cyc < 16);
      if (cyc < 16) if_a.in_pixel = px[cyc];
      #1;
      if (if_a.in_ready !== 1'b1) stalled = 1'b1;
      p     = cyc - 1;
      exp_v = (p >= 0) && (p < 16) && ((p % 8) >= 4) && ((p % 2) == 1);
      exp_q = exp_v ? {px[p-5], px[p-4], px[p-1], px[p]} : 32'h0;
      vectors++;
      if (if_a.out_valid !== exp_v || (exp_v && if_a.out_quad !== exp_q)) begin
        miscompares++;
        $display("FAIL b2b_out c%0d: got valid=%b quad=%h, need %b %h", cyc, if_a.out_valid, if_a.out_quad, exp_v, exp_q);
      end
      vectors++;
      if (if_a.frame_done !== ((p >= 0) && (p % 8 == 7))) begin
        miscompares++;
        $display("FAIL b2b_done c%0d: got %b, need %b", cyc, if_a.frame_done, (p >= 0) && (p % 8 == 7));
      end
    end
    vectors++;
    if (stalled) begin
      miscompares++;
      $display("FAIL b2b_in_ready: got stall, need none");
    end
  endtask

  task automatic test_random();
    logic [7:0]  px [96];
    logic [31:0] exp_q [$];
    int idx = 0, got_n = 0, done_n = 0, cyc = 0;
    for (int i = 0; i < 96; i++) px[i] = 8'($urandom);
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 4; c++) begin
          int top = f*32 + (2*r)*8 + 2*c;
          int bot = top + 8;
          exp_q.push_back({px[top], px[top+1], px[bot], px[bot+1]});
        end
    reset_pulse();
    while ((idx < 96 || got_n < 24) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if_b.out_ready = ($urandom_range(3) != 0);
      if_b.in_valid  = (idx < 96) && ($urandom_range(1) == 1);
      if_b.in_pixel  = (idx < 96) ? px[idx] : 8'($urandom);
      #1;
      if (if_b.frame_done === 1'b1) done_n++;
      if (if_b.out_valid && if_b.out_ready) begin
        vectors++;
        got_n++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rand_extra: got quad %h, need none", if_b.out_quad);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (if_b.out_quad !== e) begin
            miscompares++;
            $display("FAIL rand_quad %0d: got %h, need %h", got_n, if_b.out_quad, e);
          end
        end
      end
      if (if_b.in_valid && if_b.in_ready) idx++;
    end
    vectors++;
    if (cyc >= 3000) begin
      miscompares++;
      $display("FAIL rand_timeout: got %0d quads %0d pixels, need 24 96", got_n, idx);
    end
    vectors++;
    if (done_n != 3) begin
      miscompares++;
      $display("FAIL rand_frame_done: got %0d, need 3", done_n);
    end
    if_b.in_valid = 1'b0;
  endtask

`ifdef BAYER_SOF_RESYNC_EN
  task automatic test_sof();
    logic [7:0]  s [14];
    logic [31:0] got [$];
    int idx = 0, done_n = 0;
    s = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h30, 8'h40, 8'hA0,
          8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    reset_pulse();
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if_a.out_ready = 1'b1;
      if_a.in_valid  = (idx < 14);
      if (idx < 14) if_a.in_pixel = s[idx];
      if_a.in_sof    = (idx == 6) || (idx == 0);
      #1;
      if (if_a.frame_done === 1'b1) done_n++;
      if (if_a.out_valid && if_a.out_ready) got.push_back(if_a.out_quad);
      if (if_a.in_valid && if_a.in_ready) idx++;
    end
    if_a.in_sof = 1'b0;
    vectors++;
    if (got.size() != 3) begin
      miscompares++;
      $display("FAIL sof_count: got %0d quads, need 3", got.size());
    end else begin
      vectors++;
      if (got[0] !== Q1 || got[1] !== 32'hA0A1B0B1 || got[2] !== 32'hA2A3B2B3) begin
        miscompares++;
        $display("FAIL sof_data: got %h %h %h, need %h a0a1b0b1 a2a3b2b3", got[0], got[1], got[2], Q1);
      end
    end
    vectors++;
    if (done_n != 1) begin
      miscompares++;
      $display("FAIL sof_frame_done: got %0d, need 1", done_n);
    end
  endtask
`endif

  initial begin
    stream = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h30, 8'h40, 8'h31, 8'h41};
    n_rst  = 1'b1;
    idle_all();
    test_reset();
    test_basic();
    test_stall();
    test_midframe_reset();
    test_back_to_back();
    test_random();
`ifdef BAYER_SOF_RESYNC_EN
    test_sof();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bayer_quad_packer.md
Name: bayer_quad_packer

Overview:
- Upstream stage of the debayer block. Accepts a raw 8-bit RGGB Bayer pixel stream in raster order, one pixel per beat.
- Buffers each even row and pairs it with the following odd row.
- Emits one 32-bit quad {R, Gr, Gb, B} per 2x2 Bayer cell. The debayer block consumes this word directly.

Parameters:
- WIDTH, 640, pixels per row; must be even, >= 2.
- HEIGHT, 480, rows per frame; must be even, >= 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- in_pixel  in  8  raw Bayer intensity.
- in_valid  in  1  in_pixel valid this cycle.
- in_ready  out  1  block can accept a pixel this cycle.
- out_quad  out  32  [31:24]=R, [23:16]=Gr, [15:8]=Gb, [7:0]=B.
- out_valid  out  1  out_quad holds an unconsumed quad.
- out_ready  in  1  downstream accepts out_quad this cycle.
- frame_done  out  1  one-cycle pulse when the last quad of a frame is loaded into the output register.

Behaviour:
- Reset (n_rst=0, async): out_quad=0, out_valid=0, frame_done=0, col=0, row=0, state=ROW_EVEN, hold register=0. Line buffer contents are don't-care.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !out_valid || out_ready, purely combinational. No combinational path from in_valid to out_valid.
- Counters:
  - col counts 0..WIDTH-1 on each input transfer.
  - At col==WIDTH-1, col wraps to 0 and row increments.
  - At row==HEIGHT-1 with col==WIDTH-1, row wraps to 0.
- Line buffer: WIDTH/2 entries x 16 bits, indexed by col>>1.
- FSM state ROW_EVEN (row even):
  - Even col: pixel (R) held in hold[7:0].
  - Odd col: {hold, pixel} (R, Gr) written to line buffer entry col>>1.
  - No output produced.
  - Last pixel of row -> ROW_ODD.
- FSM state ROW_ODD (row odd):
  - Even col: pixel (Gb) held in hold.
  - Odd col: out_quad <= {buf[col>>1][15:8], buf[col>>1][7:0], hold, pixel} and out_valid <= 1 on the next edge. Latency is one cycle from the B-pixel transfer.
  - Last pixel of row -> ROW_EVEN.
- out_valid clears on an output transfer unless a new quad is loaded in the same cycle. Simultaneous load and drain keeps out_valid=1 and presents the new quad.
- out_quad is held stable while out_valid && !out_ready.
- frame_done is asserted for exactly one cycle on the edge that loads the quad for row HEIGHT-1, col WIDTH-1.
- Throughput: one pixel per cycle sustained when out_ready is held high. Even rows never stall on output.
- Gaps: in_valid low at any point leaves all state unchanged.
- Reset mid-frame: all counters and the FSM return to row 0 / col 0 / ROW_EVEN, and any pending quad is discarded.

Optional Feature:
- Macro: BAYER_SOF_RESYNC_EN.
- Defined:
  - Adds input port in_sof (1 bit), qualified by the input transfer.
  - A transfer with in_sof=1 treats that pixel as row 0, col 0. It forces state ROW_EVEN and discards any partially accumulated quad.
  - A pending out_quad is unaffected.
  - in_sof on a pixel that is already at row 0 / col 0 has no additional effect.
- Undefined: no in_sof port. Frame alignment relies solely on reset and counter wrap.

Test Plan:
- WIDTH=4, HEIGHT=2, out_ready=1, stream 0x10,0x20,0x11,0x21,0x30,0x40,0x31,0x41 -> quads 0x10203040 then 0x11213141. Each quad appears one cycle after pixels 0x40 and 0x41 respectively. frame_done pulses with the second quad only.
- Same stream with out_ready=0 after the first quad -> out_quad holds 0x10203040. in_ready=0 until out_ready rises. No pixel lost; the second quad follows correctly.
- Random in_valid gaps (50%) over 3 frames, WIDTH=8, HEIGHT=4 -> quad sequence matches the software model. frame_done count = 3.
- Assert n_rst after 5 pixels of a frame, then restart stream 0x10.. -> first quad 0x10203040 (stale row data not used). out_valid=0 during reset.
- Simultaneous drain and load (out_ready=1 while the B pixel arrives with out_valid=1) -> out_valid stays 1, the new quad is presented, and no cycle bubble occurs.
- BAYER_SOF_RESYNC_EN: in_sof on the 3rd pixel of an odd row -> that pixel is treated as R at row 0 / col 0. The next quad is built from the realigned data.
